// File: rtl/game_phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_phase_sequencer: per-frame game phase, lives, timer and step control |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module game_phase_sequencer #(
   parameter int CLOCK_HZ     = 25_000_000,
   parameter int START_LIVES  = 3,
   parameter int TIME_LIMIT   = 300,
   parameter int DEATH_FRAMES = 120,
   parameter int BLINK_FRAMES = 15
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       vsync,
   input  logic       start_button,
   input  logic       hit,
   input  logic       fell,
   input  logic       step_done,
   output logic       step_req,
   output logic [1:0] step_id,
   output logic       load_level,
   output logic [1:0] phase,
   output logic [3:0] lives,
   output logic [9:0] seconds,
   output logic       show_hearts,
   output logic       overrun
);

   localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
   localparam int DW = $clog2(DEATH_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [PW-1:0] c_PRESC_MAX = PW'(CLOCK_HZ - 1);
   localparam logic [DW-1:0] c_DEATH_MAX = DW'(DEATH_FRAMES - 1);
   localparam logic [BW-1:0] c_BLINK_MAX = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      TITLE     = 2'd0,
      PLAYING   = 2'd1,
      DYING     = 2'd2,
      GAME_OVER = 2'd3
   } phase_t;

   phase_t          r_phase;
   logic [PW-1:0]   r_presc;
   logic [DW-1:0]   r_death_cnt;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_vsync_prev;
   logic            r_start_prev;

   logic w_tick, w_press, w_accept, w_playing, w_death, w_wrap, w_timeout, w_lose;
   logic w_death_done, w_blink;

   assign phase        = r_phase;
   assign w_tick       = !vsync && r_vsync_prev;
   assign w_press      = start_button && !r_start_prev;
   assign w_accept     = step_req && step_done;
   assign w_playing    = (r_phase == PLAYING);
   assign w_death      = w_playing && w_accept && (step_id == 2'd3) && (hit || fell);
   assign w_wrap       = w_playing && (r_presc == c_PRESC_MAX);
   assign w_timeout    = w_wrap && (seconds == 10'd1);
   // a timeout and a death in the same cycle merge into one life lost
   assign w_lose       = w_death || w_timeout;
   assign w_death_done = w_tick && (r_death_cnt == c_DEATH_MAX);
   assign w_blink      = w_tick && (r_blink_cnt == c_BLINK_MAX);

   always_ff @(posedge vga_clock) begin
      if (!reset) begin
         r_phase      <= TITLE;
         lives        <= 4'(START_LIVES);
         seconds      <= 10'(TIME_LIMIT);
         step_req     <= 1'b0;
         step_id      <= 2'd0;
         load_level   <= 1'b0;
         show_hearts  <= 1'b0;
         overrun      <= 1'b0;
         r_presc      <= '0;
         r_death_cnt  <= '0;
         r_blink_cnt  <= '0;
         r_vsync_prev <= 1'b1;
         r_start_prev <= 1'b1;
      end else begin
         r_vsync_prev <= vsync;
         r_start_prev <= start_button;
         load_level   <= 1'b0;

         // an in-flight step always completes; only continue while still playing
         if (w_accept) begin
            if ((step_id == 2'd3) || !w_playing || w_lose) begin
               step_req <= 1'b0;
               step_id  <= 2'd0;
            end else begin
               step_id <= step_id + 2'd1;
            end
         end else if (w_tick && w_playing && !w_timeout && !step_req) begin
            step_req <= 1'b1;
            step_id  <= 2'd0;
         end
         if (w_tick && w_playing && step_req)
            overrun <= 1'b1;

         case (r_phase)
            TITLE: begin
               if (w_press) begin
                  lives       <= 4'(START_LIVES);
                  seconds     <= 10'(TIME_LIMIT);
                  load_level  <= 1'b1;
                  r_presc     <= '0;
                  show_hearts <= 1'b1;
                  r_phase     <= PLAYING;
               end
            end
            PLAYING: begin
               r_presc <= w_wrap ? '0 : r_presc + 1'b1;
               if (w_wrap && (seconds > 10'd1))
                  seconds <= seconds - 10'd1;
               else if (w_timeout)
                  seconds <= 10'd0;
               if (w_lose) begin
                  lives       <= (lives == 4'd0) ? 4'd0 : lives - 4'd1;
                  show_hearts <= 1'b0;
                  r_death_cnt <= '0;
                  r_blink_cnt <= '0;
                  r_phase     <= DYING;
               end
            end
            DYING: begin
               if (w_death_done) begin
                  if (lives == 4'd0) begin
                     show_hearts <= 1'b0;
                     r_phase     <= GAME_OVER;
                  end else begin
                     seconds     <= 10'(TIME_LIMIT);
                     load_level  <= 1'b1;
                     r_presc     <= '0;
                     show_hearts <= 1'b1;
                     r_phase     <= PLAYING;
                  end
               end else if (w_tick) begin
                  r_death_cnt <= r_death_cnt + 1'b1;
                  if (w_blink) begin
                     show_hearts <= !show_hearts;
                     r_blink_cnt <= '0;
                  end else begin
                     r_blink_cnt <= r_blink_cnt + 1'b1;
                  end
               end
            end
            GAME_OVER: begin
               if (w_press)
                  r_phase <= TITLE;
            end
            default: r_phase <= TITLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_game_phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_game_phase_sequencer: scoreboard bench, two differently sized DUTs     |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_game_phase_sequencer;

   localparam int F_PHASE = 0, F_LIVES = 1, F_SEC = 2, F_HEARTS = 3;
   localparam int F_LOAD = 4, F_REQ = 5, F_ID = 6, F_OVR = 7;

   typedef struct {
      int cyc;
      bit dut;
      int fld;
      int val;
   } chk_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic a_vsync = 1'b1, a_start = 1'b0, a_hit = 1'b0, a_fell = 1'b0, a_done = 1'b0;
   logic b_vsync = 1'b1, b_start = 1'b0, b_hit = 1'b0, b_fell = 1'b0, b_done = 1'b0;
   logic a_req, a_load, a_hearts, a_ovr, b_req, b_load, b_hearts, b_ovr;
   logic [1:0] a_id, a_phase, b_id, b_phase;
   logic [3:0] a_lives, b_lives;
   logic [9:0] a_sec, b_sec;

   game_phase_sequencer #(.CLOCK_HZ(1000), .START_LIVES(3), .TIME_LIMIT(300),
                          .DEATH_FRAMES(120), .BLINK_FRAMES(15)) u_a (
      .vga_clock(clk), .reset(rst_n), .vsync(a_vsync), .start_button(a_start),
      .hit(a_hit), .fell(a_fell), .step_done(a_done), .step_req(a_req),
      .step_id(a_id), .load_level(a_load), .phase(a_phase), .lives(a_lives),
      .seconds(a_sec), .show_hearts(a_hearts), .overrun(a_ovr));

   game_phase_sequencer #(.CLOCK_HZ(4), .START_LIVES(3), .TIME_LIMIT(2),
                          .DEATH_FRAMES(2), .BLINK_FRAMES(1)) u_b (
      .vga_clock(clk), .reset(rst_n), .vsync(b_vsync), .start_button(b_start),
      .hit(b_hit), .fell(b_fell), .step_done(b_done), .step_req(b_req),
      .step_id(b_id), .load_level(b_load), .phase(b_phase), .lives(b_lives),
      .seconds(b_sec), .show_hearts(b_hearts), .overrun(b_ovr));

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   end_req = 1'b0;
   chk_t tq[$];
   int   aq[$];
   int   bq[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get_val(input bit d, input int f);
      case (f)
         F_PHASE:  return d ? int'(b_phase)  : int'(a_phase);
         F_LIVES:  return d ? int'(b_lives)  : int'(a_lives);
         F_SEC:    return d ? int'(b_sec)    : int'(a_sec);
         F_HEARTS: return d ? int'(b_hearts) : int'(a_hearts);
         F_LOAD:   return d ? int'(b_load)   : int'(a_load);
         F_REQ:    return d ? int'(b_req)    : int'(a_req);
         F_ID:     return d ? int'(b_id)     : int'(a_id);
         default:  return d ? int'(b_ovr)    : int'(a_ovr);
      endcase
   endfunction

   function automatic string fname(input int f);
      case (f)
         F_PHASE:  return "phase";
         F_LIVES:  return "lives";
         F_SEC:    return "seconds";
         F_HEARTS: return "show_hearts";
         F_LOAD:   return "load_level";
         F_REQ:    return "step_req";
         F_ID:     return "step_id";
         default:  return "overrun";
      endcase
   endfunction

   // expectation for field f of a DUT, due dly edges from now
   task automatic expect_at(input bit d, input int f, input int v, input int dly);
      chk_t c;
      c.cyc = cyc + dly;
      c.dut = d;
      c.fld = f;
      c.val = v;
      tq.push_back(c);
   endtask

   task automatic acc(input bit d, input int id);
      if (d) bq.push_back(id);
      else   aq.push_back(id);
   endtask

   task automatic tk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: sole owner of the check counters
   always @(negedge clk) begin
      int act;
      int e;
      if (!end_req) begin
         for (int i = tq.size() - 1; i >= 0; i--) begin
            if (tq[i].cyc <= cyc) begin
               checks++;
               act = get_val(tq[i].dut, tq[i].fld);
               if (tq[i].cyc != cyc || act != tq[i].val) begin
                  errors++;
                  $display("FAIL %s.%s cycle %0d: got %0d expected %0d",
                           tq[i].dut ? "B" : "A", fname(tq[i].fld), tq[i].cyc, act, tq[i].val);
               end
               tq.delete(i);
            end
         end
         if (a_req && a_done) begin
            checks++;
            if (aq.size() == 0) begin
               errors++;
               $display("FAIL A.step_accept cycle %0d: got step %0d expected none", cyc, a_id);
            end else begin
               e = aq.pop_front();
               if (int'(a_id) != e) begin
                  errors++;
                  $display("FAIL A.step_accept cycle %0d: got step %0d expected %0d", cyc, a_id, e);
               end
            end
         end
         if (b_req && b_done) begin
            checks++;
            if (bq.size() == 0) begin
               errors++;
               $display("FAIL B.step_accept cycle %0d: got step %0d expected none", cyc, b_id);
            end else begin
               e = bq.pop_front();
               if (int'(b_id) != e) begin
                  errors++;
                  $display("FAIL B.step_accept cycle %0d: got step %0d expected %0d", cyc, b_id, e);
               end
            end
         end
      end else begin
         foreach (tq[i]) begin
            checks++;
            errors++;
            $display("FAIL %s.%s: got no sample expected %0d", tq[i].dut ? "B" : "A",
                     fname(tq[i].fld), tq[i].val);
         end
         foreach (aq[i]) begin
            checks++;
            errors++;
            $display("FAIL A.step_accept: got none expected step %0d", aq[i]);
         end
         foreach (bq[i]) begin
            checks++;
            errors++;
            $display("FAIL B.step_accept: got none expected step %0d", bq[i]);
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   task automatic a_death(input bit use_hit, input int exp_lives);
      a_done = 1'b1;
      a_hit  = use_hit;
      a_fell = !use_hit;
      for (int i = 0; i < 4; i++) acc(1'b0, i);
      a_vsync = 1'b0;
      expect_at(1'b0, F_REQ, 1, 1);
      expect_at(1'b0, F_ID, 0, 1);
      expect_at(1'b0, F_ID, 3, 4);
      expect_at(1'b0, F_PHASE, 1, 4);
      expect_at(1'b0, F_PHASE, 2, 5);
      expect_at(1'b0, F_LIVES, exp_lives, 5);
      expect_at(1'b0, F_REQ, 0, 5);
      expect_at(1'b0, F_HEARTS, 0, 5);
      tk(1);
      a_vsync = 1'b1;
      tk(5);
      a_hit  = 1'b0;
      a_fell = 1'b0;
      a_done = 1'b0;
      tk(2);
   endtask

   task automatic a_dying(input int exp_lives);
      for (int f = 1; f <= 120; f++) begin
         a_vsync = 1'b0;
         if (f < 120) begin
            expect_at(1'b0, F_PHASE, 2, 1);
            expect_at(1'b0, F_HEARTS, (f / 15) % 2, 1);
         end else if (exp_lives == 0) begin
            expect_at(1'b0, F_PHASE, 3, 1);
            expect_at(1'b0, F_HEARTS, 0, 1);
            expect_at(1'b0, F_LIVES, 0, 1);
            expect_at(1'b0, F_LOAD, 0, 1);
            expect_at(1'b0, F_LOAD, 0, 2);
         end else begin
            expect_at(1'b0, F_PHASE, 1, 1);
            expect_at(1'b0, F_LOAD, 1, 1);
            expect_at(1'b0, F_LIVES, exp_lives, 1);
            expect_at(1'b0, F_SEC, 300, 1);
            expect_at(1'b0, F_HEARTS, 1, 1);
            expect_at(1'b0, F_LOAD, 0, 2);
         end
         tk(1);
         a_vsync = 1'b1;
         tk(3);
      end
   endtask

   initial begin
      tk(3);
      expect_at(1'b0, F_PHASE, 0, 0);
      expect_at(1'b0, F_LIVES, 3, 0);
      expect_at(1'b0, F_SEC, 300, 0);
      expect_at(1'b0, F_REQ, 0, 0);
      expect_at(1'b0, F_ID, 0, 0);
      expect_at(1'b0, F_LOAD, 0, 0);
      expect_at(1'b0, F_HEARTS, 0, 0);
      expect_at(1'b0, F_OVR, 0, 0);
      expect_at(1'b1, F_SEC, 2, 0);
      expect_at(1'b1, F_PHASE, 0, 0);
      rst_n = 1'b1;
      tk(2);

      // A: start press
      a_start = 1'b1;
      expect_at(1'b0, F_PHASE, 1, 1);
      expect_at(1'b0, F_LOAD, 1, 1);
      expect_at(1'b0, F_LIVES, 3, 1);
      expect_at(1'b0, F_SEC, 300, 1);
      expect_at(1'b0, F_HEARTS, 1, 1);
      expect_at(1'b0, F_LOAD, 0, 2);
      tk(1);
      a_start = 1'b0;
      tk(2);

      // A: back-to-back steps
      a_done = 1'b1;
      for (int i = 0; i < 4; i++) acc(1'b0, i);
      a_vsync = 1'b0;
      expect_at(1'b0, F_REQ, 0, 0);
      for (int i = 0; i < 4; i++) begin
         expect_at(1'b0, F_REQ, 1, i + 1);
         expect_at(1'b0, F_ID, i, i + 1);
      end
      expect_at(1'b0, F_REQ, 0, 5);
      expect_at(1'b0, F_ID, 0, 5);
      expect_at(1'b0, F_OVR, 0, 5);
      tk(1);
      a_vsync = 1'b1;
      tk(6);

      // A: stalled sequence across two ticks
      a_done  = 1'b0;
      a_vsync = 1'b0;
      expect_at(1'b0, F_REQ, 1, 1);
      expect_at(1'b0, F_ID, 0, 1);
      expect_at(1'b0, F_OVR, 0, 1);
      tk(1);
      a_vsync = 1'b1;
      tk(3);
      a_vsync = 1'b0;
      expect_at(1'b0, F_OVR, 0, 0);
      expect_at(1'b0, F_OVR, 1, 1);
      expect_at(1'b0, F_ID, 0, 1);
      expect_at(1'b0, F_REQ, 1, 1);
      tk(1);
      a_vsync = 1'b1;
      tk(3);
      for (int i = 0; i < 4; i++) acc(1'b0, i);
      a_done = 1'b1;
      expect_at(1'b0, F_ID, 1, 1);
      expect_at(1'b0, F_REQ, 0, 4);
      expect_at(1'b0, F_OVR, 1, 4);
      tk(5);
      a_done = 1'b0;

      // A: start ignored while playing
      a_start = 1'b1;
      expect_at(1'b0, F_PHASE, 1, 1);
      expect_at(1'b0, F_LOAD, 0, 1);
      expect_at(1'b0, F_LIVES, 3, 1);
      tk(1);
      a_start = 1'b0;
      tk(2);

      // A: three deaths down to game over, then back to title
      a_death(1'b0, 2);
      a_dying(2);
      a_death(1'b1, 1);
      a_dying(1);
      a_death(1'b1, 0);
      a_dying(0);
      a_start = 1'b1;
      expect_at(1'b0, F_PHASE, 0, 1);
      expect_at(1'b0, F_LIVES, 0, 1);
      expect_at(1'b0, F_HEARTS, 0, 1);
      expect_at(1'b0, F_LOAD, 0, 1);
      tk(1);
      a_start = 1'b0;
      tk(2);

      // B: timeout coinciding with a step-3 hit
      b_start = 1'b1;
      expect_at(1'b1, F_PHASE, 1, 1);
      expect_at(1'b1, F_LOAD, 1, 1);
      expect_at(1'b1, F_LOAD, 0, 2);
      expect_at(1'b1, F_SEC, 2, 4);
      expect_at(1'b1, F_SEC, 1, 5);
      expect_at(1'b1, F_PHASE, 1, 5);
      tk(1);
      b_start = 1'b0;
      tk(3);
      b_vsync = 1'b0;
      b_done  = 1'b1;
      b_hit   = 1'b1;
      for (int i = 0; i < 4; i++) acc(1'b1, i);
      expect_at(1'b1, F_ID, 3, 4);
      expect_at(1'b1, F_SEC, 1, 4);
      expect_at(1'b1, F_PHASE, 1, 4);
      expect_at(1'b1, F_PHASE, 2, 5);
      expect_at(1'b1, F_LIVES, 2, 5);
      expect_at(1'b1, F_SEC, 0, 5);
      expect_at(1'b1, F_REQ, 0, 5);
      expect_at(1'b1, F_SEC, 0, 8);
      tk(1);
      b_vsync = 1'b1;
      tk(5);
      b_hit  = 1'b0;
      b_done = 1'b0;

      // B: two death frames back to playing
      b_vsync = 1'b0;
      expect_at(1'b1, F_PHASE, 2, 1);
      tk(1);
      b_vsync = 1'b1;
      tk(3);
      b_vsync = 1'b0;
      expect_at(1'b1, F_PHASE, 1, 1);
      expect_at(1'b1, F_LOAD, 1, 1);
      expect_at(1'b1, F_SEC, 2, 1);
      expect_at(1'b1, F_LIVES, 2, 1);
      expect_at(1'b1, F_HEARTS, 1, 1);
      tk(1);
      b_vsync = 1'b1;

      // B: timeout while step 1 is outstanding
      tk(5);
      b_vsync = 1'b0;
      acc(1'b1, 0);
      tk(1);
      b_vsync = 1'b1;
      b_done  = 1'b1;
      tk(1);
      b_done = 1'b0;
      expect_at(1'b1, F_PHASE, 2, 1);
      expect_at(1'b1, F_LIVES, 1, 1);
      expect_at(1'b1, F_REQ, 1, 1);
      expect_at(1'b1, F_ID, 1, 1);
      expect_at(1'b1, F_SEC, 0, 1);
      tk(3);
      expect_at(1'b1, F_REQ, 1, 0);
      expect_at(1'b1, F_ID, 1, 0);
      acc(1'b1, 1);
      b_done = 1'b1;
      expect_at(1'b1, F_REQ, 0, 1);
      expect_at(1'b1, F_ID, 0, 1);
      tk(4);
      expect_at(1'b1, F_REQ, 0, 0);
      tk(1);
      b_done = 1'b0;

      tk(5);
      end_req = 1'b1;
   end

endmodule
`default_nettype wire
